// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of a sampled PWM waveform, rising edge to
// rising edge, and reports a stuck line when no rising edge arrives within 2^CLEN-1 cycles.
module pwm_capture #(
    parameter int unsigned CLEN = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            signal,
    output logic [CLEN-1:0] period_cnt,
    output logic [CLEN-1:0] high_cnt,
    output logic            valid,
    output logic            stuck,
    output logic            level
);

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StMeasure
    } state_e;

    localparam logic [CLEN-1:0] MaxCnt = '1;
    localparam logic [CLEN-1:0] OneCnt = CLEN'(1);

    state_e          state_q, state_d;
    logic            prev_q;
    logic [CLEN-1:0] cnt_q, cnt_d;
    logic [CLEN-1:0] hi_q, hi_d;
    logic [CLEN-1:0] period_q, period_d;
    logic [CLEN-1:0] high_q, high_d;
    logic            valid_q, valid_d;
    logic            stuck_q, stuck_d;
    logic            level_q, level_d;

    logic            rise;
    logic            timeout;
    logic [CLEN-1:0] sig_ext;

    assign rise    = signal & ~prev_q;
    // A rise on the same sample as cnt==MAX wins and is reported as a period of MAX.
    assign timeout = (cnt_q == MaxCnt) & ~rise;
    assign sig_ext = {{(CLEN-1){1'b0}}, signal};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        stuck_d  = stuck_q;
        level_d  = level_q;

        if (!en) begin
            state_d = StIdle;
            cnt_d   = '0;
            hi_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d   = '0;
                    hi_d    = '0;
                    state_d = StArm;
                end
                StArm, StMeasure: begin
                    if (rise) begin
                        // The arming period is partial, so only MEASURE reports on a rise.
                        if (state_q == StMeasure) begin
                            period_d = cnt_q;
                            high_d   = hi_q;
                            valid_d  = 1'b1;
                            stuck_d  = 1'b0;
                        end
                        cnt_d   = OneCnt;
                        hi_d    = OneCnt;
                        state_d = StMeasure;
                    end else if (timeout) begin
                        period_d = '0;
                        high_d   = '0;
                        valid_d  = 1'b1;
                        stuck_d  = 1'b1;
                        level_d  = signal;
                        cnt_d    = '0;
                        hi_d     = '0;
                        state_d  = StArm;
                    end else begin
                        cnt_d = cnt_q + OneCnt;
                        if (state_q == StMeasure) begin
                            hi_d = hi_q + sig_ext;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    hi_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
            level_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= signal;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
            level_q  <= level_d;
        end
    end

    assign period_cnt = period_q;
    assign high_cnt   = high_q;
    assign valid      = valid_q;
    assign stuck      = stuck_q;
    assign level      = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with CLEN=4 (MAX=15); expected values are hand-derived.
module tb_pwm_capture;

    localparam int unsigned CLEN = 4;

    logic            clk;
    logic            rst;
    logic            en;
    logic            signal;
    logic [CLEN-1:0] period_cnt;
    logic [CLEN-1:0] high_cnt;
    logic            valid;
    logic            stuck;
    logic            level;

    int tests;
    int fails;

    pwm_capture #(.CLEN(CLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .signal     (signal),
        .period_cnt (period_cnt),
        .high_cnt   (high_cnt),
        .valid      (valid),
        .stuck      (stuck),
        .level      (level)
    );

    always #5 clk = ~clk;

    // Apply one sample; on return the outputs reflect the edge that sampled it.
    task automatic cyc(input logic s);
        signal = s;
        @(posedge clk);
        #1;
    endtask

    // Drop to IDLE, then enter ARM with cnt=0 and prev=0.
    task automatic restart();
        en = 1'b0;
        cyc(1'b0);
        en = 1'b1;
        cyc(1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            signal = i[0];
            @(posedge clk);
            #1;
        end
        tests++; if (period_cnt !== 4'd0) begin fails++; $display("FAIL reset_period: got %0d want 0", period_cnt); end
        tests++; if (high_cnt !== 4'd0) begin fails++; $display("FAIL reset_high: got %0d want 0", high_cnt); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
        tests++; if (stuck !== 1'b0) begin fails++; $display("FAIL reset_stuck: got %b want 0", stuck); end
        tests++; if (level !== 1'b0) begin fails++; $display("FAIL reset_level: got %b want 0", level); end
        rst = 1'b1;
        en  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(i[0]);
            tests++;
            if (valid !== 1'b0) begin
                fails++; $display("FAIL idle_valid cycle %0d: got %b want 0", i, valid);
            end
        end
    endtask

    task automatic test_pwm_7_4();
        logic [6:0] pat;
        logic expv;
        pat = 7'b1111000;
        restart();
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < 7; k++) begin
                cyc(pat[6-k]);
                expv = (k == 0 && p > 0);
                tests++;
                if (valid !== expv) begin
                    fails++; $display("FAIL pwm74_valid p%0d k%0d: got %b want %b", p, k, valid, expv);
                end
                if (expv) begin
                    tests++;
                    if (period_cnt !== 4'd7 || high_cnt !== 4'd4 || stuck !== 1'b0) begin
                        fails++;
                        $display("FAIL pwm74_result p%0d: got %0d/%0d stuck %b want 7/4 stuck 0",
                                 p, period_cnt, high_cnt, stuck);
                    end
                end
            end
        end
    endtask

    task automatic test_short_duty();
        logic [6:0] pat;
        logic expv;
        restart();
        for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < 2; k++) begin
                cyc(k == 0);
                expv = (k == 0 && p > 0);
                tests++;
                if (valid !== expv) begin
                    fails++; $display("FAIL alt_valid p%0d k%0d: got %b want %b", p, k, valid, expv);
                end
                if (expv) begin
                    tests++;
                    if (period_cnt !== 4'd2 || high_cnt !== 4'd1 || stuck !== 1'b0) begin
                        fails++;
                        $display("FAIL alt_result p%0d: got %0d/%0d stuck %b want 2/1 stuck 0",
                                 p, period_cnt, high_cnt, stuck);
                    end
                end
            end
        end
        pat = 7'b1000000;
        restart();
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 7; k++) begin
                cyc(pat[6-k]);
                expv = (k == 0 && p > 0);
                tests++;
                if (valid !== expv) begin
                    fails++; $display("FAIL p71_valid p%0d k%0d: got %b want %b", p, k, valid, expv);
                end
                if (expv) begin
                    tests++;
                    if (period_cnt !== 4'd7 || high_cnt !== 4'd1 || stuck !== 1'b0) begin
                        fails++;
                        $display("FAIL p71_result p%0d: got %0d/%0d stuck %b want 7/1 stuck 0",
                                 p, period_cnt, high_cnt, stuck);
                    end
                end
            end
        end
    endtask

    task automatic test_stuck_low();
        logic expv;
        restart();
        for (int n = 1; n <= 48; n++) begin
            cyc(1'b0);
            expv = (n % 16 == 0);
            tests++;
            if (valid !== expv) begin
                fails++; $display("FAIL stuck0_valid n%0d: got %b want %b", n, valid, expv);
            end
            if (expv) begin
                tests++;
                if (stuck !== 1'b1 || level !== 1'b0 || period_cnt !== 4'd0 || high_cnt !== 4'd0) begin
                    fails++;
                    $display("FAIL stuck0_event n%0d: got stuck %b level %b %0d/%0d want 1 0 0/0",
                             n, stuck, level, period_cnt, high_cnt);
                end
            end
        end
    endtask

    task automatic test_stuck_high();
        logic expv;
        en = 1'b0;
        cyc(1'b1);
        en = 1'b1;
        cyc(1'b1);
        for (int n = 1; n <= 48; n++) begin
            cyc(1'b1);
            expv = (n % 16 == 0);
            tests++;
            if (valid !== expv) begin
                fails++; $display("FAIL stuck1_valid n%0d: got %b want %b", n, valid, expv);
            end
            if (expv) begin
                tests++;
                if (stuck !== 1'b1 || level !== 1'b1 || period_cnt !== 4'd0 || high_cnt !== 4'd0) begin
                    fails++;
                    $display("FAIL stuck1_event n%0d: got stuck %b level %b %0d/%0d want 1 1 0/0",
                             n, stuck, level, period_cnt, high_cnt);
                end
            end
        end
    endtask

    task automatic test_boundary_15();
        logic expv;
        restart();
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 15; k++) begin
                cyc(k == 0);
                expv = (k == 0 && p > 0);
                tests++;
                if (valid !== expv) begin
                    fails++; $display("FAIL p15_valid p%0d k%0d: got %b want %b", p, k, valid, expv);
                end
                if (expv) begin
                    tests++;
                    if (period_cnt !== 4'd15 || high_cnt !== 4'd1 || stuck !== 1'b0) begin
                        fails++;
                        $display("FAIL p15_result p%0d: got %0d/%0d stuck %b want 15/1 stuck 0",
                                 p, period_cnt, high_cnt, stuck);
                    end
                end
            end
        end
    endtask

    task automatic test_boundary_16();
        logic [6:0] pat;
        logic expv;
        pat = 7'b1111000;
        restart();
        cyc(1'b1);
        tests++;
        if (valid !== 1'b0) begin fails++; $display("FAIL p16_sync: got %b want 0", valid); end
        for (int k = 1; k <= 15; k++) begin
            cyc(1'b0);
            expv = (k == 15);
            tests++;
            if (valid !== expv) begin
                fails++; $display("FAIL p16_valid k%0d: got %b want %b", k, valid, expv);
            end
        end
        tests++;
        if (stuck !== 1'b1 || level !== 1'b0 || period_cnt !== 4'd0) begin
            fails++;
            $display("FAIL p16_event: got stuck %b level %b period %0d want 1 0 0",
                     stuck, level, period_cnt);
        end
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 7; k++) begin
                cyc(pat[6-k]);
                expv = (k == 0 && p > 0);
                tests++;
                if (valid !== expv) begin
                    fails++; $display("FAIL p16_resync_valid p%0d k%0d: got %b want %b", p, k, valid, expv);
                end
            end
        end
        cyc(1'b1);
        tests++;
        if (valid !== 1'b1 || period_cnt !== 4'd7 || high_cnt !== 4'd4 || stuck !== 1'b0) begin
            fails++;
            $display("FAIL p16_resync_result: got valid %b %0d/%0d stuck %b want 1 7/4 0",
                     valid, period_cnt, high_cnt, stuck);
        end
    endtask

    // use_rst=0: one-cycle en drop; use_rst=1: asynchronous reset pulse.
    task automatic test_interrupt(input bit use_rst);
        logic [6:0] pat;
        logic expv;
        pat = 7'b1111000;
        restart();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 7; k++) begin
                cyc(pat[6-k]);
            end
        end
        cyc(1'b1);
        tests++;
        if (valid !== 1'b1 || period_cnt !== 4'd7 || high_cnt !== 4'd4) begin
            fails++;
            $display("FAIL intr%0d_pre: got valid %b %0d/%0d want 1 7/4", use_rst, valid, period_cnt, high_cnt);
        end
        cyc(1'b1);
        cyc(1'b1);
        if (use_rst) begin
            rst = 1'b0;
            #2;
            tests++;
            if (period_cnt !== 4'd0 || high_cnt !== 4'd0 || valid !== 1'b0) begin
                fails++;
                $display("FAIL intr_rst_clear: got %0d/%0d valid %b want 0/0 0", period_cnt, high_cnt, valid);
            end
            rst = 1'b1;
            cyc(1'b1);
        end else begin
            en = 1'b0;
            cyc(1'b1);
            en = 1'b1;
        end
        for (int k = 4; k < 7; k++) begin
            cyc(pat[6-k]);
            tests++;
            if (valid !== 1'b0) begin
                fails++; $display("FAIL intr%0d_cut k%0d: got %b want 0", use_rst, k, valid);
            end
        end
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 7; k++) begin
                cyc(pat[6-k]);
                expv = (k == 0 && p > 0);
                tests++;
                if (valid !== expv) begin
                    fails++; $display("FAIL intr%0d_valid p%0d k%0d: got %b want %b", use_rst, p, k, valid, expv);
                end
                if (expv) begin
                    tests++;
                    if (period_cnt !== 4'd7 || high_cnt !== 4'd4 || stuck !== 1'b0) begin
                        fails++;
                        $display("FAIL intr%0d_result p%0d: got %0d/%0d stuck %b want 7/4 0",
                                 use_rst, p, period_cnt, high_cnt, stuck);
                    end
                end
            end
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        clk    = 1'b0;
        rst    = 1'b1;
        en     = 1'b0;
        signal = 1'b0;
        #3;
        rst = 1'b0;
        test_reset();
        test_pwm_7_4();
        test_short_duty();
        test_stuck_low();
        test_stuck_high();
        test_boundary_15();
        test_boundary_16();
        test_interrupt(1'b0);
        test_interrupt(1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Downstream consumer of the pwm stage: samples a single-bit PWM waveform and measures period and high time in clk cycles, rising edge to rising edge.
- Emits one result per completed period with a valid strobe; flags stuck-at-0/1 lines (amplitude 0 or amplitude == duty) via timeout.
- Used as the loopback checker and feedback sensor behind pwm, same clock domain.

Parameters:
CLEN, 8, width of the counters and result ports; longest measurable period is 2^CLEN-1 cycles.

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  reset, asynchronous, active-low
en  input  1  capture enable; low forces IDLE synchronously
signal  input  1  PWM waveform, synchronous to clk
period_cnt  output  CLEN  cycles in last complete period
high_cnt  output  CLEN  cycles signal was 1 in last complete period
valid  output  1  one-cycle strobe: new result or stuck event
stuck  output  1  qualifies valid: 1 = timeout, no rising edge seen
level  output  1  on a stuck event, sampled level of signal (0 or 1)

Behaviour:
- Reset (rst low, asynchronous): state IDLE; prev, cnt, hi cleared; period_cnt=0, high_cnt=0, valid=0, stuck=0, level=0.
- Sampling: prev <= signal every posedge in all states. rise = signal & ~prev, evaluated on the current sample.
- Terminology: MAX = 2^CLEN-1.
- IDLE:
  - cnt=0, hi=0, valid=0.
  - Result outputs hold their last values.
  - If en=1, go to ARM on the next cycle.
- ARM (discards the partial first period):
  - cnt increments each cycle.
  - On rise: go to MEASURE with cnt<=1 and hi<=1.
  - Timeout rule applies.
- MEASURE:
  - With no rise: cnt<=cnt+1; hi<=hi+signal.
  - On rise: at the same posedge, period_cnt<=cnt, high_cnt<=hi, valid<=1, stuck<=0; then cnt<=1 and hi<=1. Stay in MEASURE.
- Latency: valid is high during the cycle right after the posedge that sampled the rise.
- Timeout (ARM or MEASURE):
  - Trigger: cnt==MAX and no rise on this sample.
  - Outputs: valid<=1, stuck<=1, level<=signal, period_cnt<=0, high_cnt<=0.
  - Counters: cnt<=0, hi<=0; state goes to ARM.
  - A constant line therefore reports a stuck event every MAX+1 cycles.
- Simultaneous events:
  - Rise and cnt==MAX on the same sample: rise wins, and the period is reported as MAX.
  - en=0 overrides everything: next state IDLE, no valid issued in that cycle.
- hi can never exceed cnt, so it needs no saturation.
- valid is asserted for exactly one cycle per event and never in consecutive cycles, except for a period-1 signal, which cannot occur because period ≥ 2 requires a 0 sample.
- Reset or en drop mid-period: the partial measurement is discarded. After re-enable, the first result comes only after two rising edges.
- level and stuck hold until the next valid.

Test Plan (CLEN=4, MAX=15):
- Reset: rst low with the signal toggling -> all outputs 0; after release with en=0, valid stays 0 for 20 cycles.
- PWM pattern 1111000 (pwm duty=7, ampl=4), en=1 -> first valid after the second rise, then valid every 7 cycles with period_cnt=7, high_cnt=4, stuck=0.
- Alternating 10 -> period_cnt=2, high_cnt=1 on every second cycle; also the pattern 1000000 gives period 7, high 1.
- Constant 0 (ampl=0) from ARM entry -> valid with stuck=1, level=0, period_cnt=0 at cycle 16 after ARM entry, repeating every 16 cycles. Constant 1 (ampl=duty) -> same timing with level=1.
- Boundary: a period of exactly 15 cycles (1 high, 14 low) -> period_cnt=15, high_cnt=1, stuck=0, with no timeout. A period of 16 -> stuck event with level=0, then ARM and re-sync on the next rise.
- Mid-operation interruption: en=0 for 1 cycle, or an rst pulse, during a period -> no valid for the cut period; results resume with correct 7/4 values only after two further rises.
